pixel_write_arbiter: RTL and testbench

- Consumer end of the drawer enable/active handshake, sitting between the game's pixel drawers (life, score, sprite, background) and the VGA adapter's single write port.
- Watches each client's active request and grants enable to exactly one client at a time, round-robin.
- Registers the granted client's x/y/colour/write onto the VGA port.
- Watchdog force-releases a client that holds its grant too long.

---
 rtl/draw_pkg.sv | 17 +
 rtl/rr_pick.sv | 34 +++
 rtl/pixel_write_arbiter.sv | 138 +++++++++++++
 tb/tb_pixel_write_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// rtl/draw_pkg.sv - shared pixel-drawer field widths, arbiter states and colours
package draw_pkg;

   localparam int X_W = 8;
   localparam int Y_W = 7;
   localparam int C_W = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } arb_state_e;

   localparam logic [C_W-1:0] BLACK = 3'b000;
   localparam logic [C_W-1:0] WHITE = 3'b111;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin finder: first set req bit after ptr, wrapping at N
module rr_pick #(
   parameter int N  = 4,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [PW-1:0] idx,
   output logic          valid
);

   logic [PW:0]   sum;
   logic [PW-1:0] cand;

   // Walk the search order backwards so the nearest candidate after ptr wins last.
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      sum   = '0;
      cand  = '0;
      for (int k = N; k >= 1; k--) begin
         sum = {1'b0, ptr} + (PW+1)'(k);
         if (sum >= (PW+1)'(N)) begin
            sum = sum - (PW+1)'(N);
         end
         cand = sum[PW-1:0];
         if (req[cand]) begin
            idx   = cand;
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pixel_write_arbiter.sv
// rtl/pixel_write_arbiter.sv - round-robin owner of the VGA write port with watchdog release
module pixel_write_arbiter
   import draw_pkg::*;
#(
   parameter int N       = 4,
   parameter int TIMEOUT = 4096,
   parameter int TW      = 13
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [N-1:0]     req_active,
   input  logic [8*N-1:0]   req_x,
   input  logic [7*N-1:0]   req_y,
   input  logic [3*N-1:0]   req_colour,
   input  logic [N-1:0]     req_write,
   output logic [N-1:0]     grant,
   output logic [X_W-1:0]   vga_x,
   output logic [Y_W-1:0]   vga_y,
   output logic [C_W-1:0]   vga_colour,
   output logic             vga_plot,
   output logic             busy,
   output logic             timeout_err
);

   localparam int PW = $clog2(N);

   arb_state_e    state_q, state_d;
   logic [PW-1:0] owner_q, owner_d;
   logic [PW-1:0] rr_ptr_q, rr_ptr_d;
   logic [TW-1:0] wd_cnt_q, wd_cnt_d;
   logic          timeout_err_q, timeout_err_d;

   logic [X_W-1:0] vga_x_q;
   logic [Y_W-1:0] vga_y_q;
   logic [C_W-1:0] vga_colour_q;
   logic           vga_plot_q;

   logic [PW-1:0]  pick_idx;
   logic           pick_valid;
   logic [X_W-1:0] sel_x;
   logic [Y_W-1:0] sel_y;
   logic [C_W-1:0] sel_colour;

   rr_pick #(.N(N), .PW(PW)) u_rr_pick (
      .req   (req_active),
      .ptr   (rr_ptr_q),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q       <= IDLE;
         owner_q       <= '0;
         rr_ptr_q      <= PW'(N-1);
         wd_cnt_q      <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         rr_ptr_q      <= rr_ptr_d;
         wd_cnt_q      <= wd_cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      rr_ptr_d      = rr_ptr_q;
      wd_cnt_d      = wd_cnt_q;
      timeout_err_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               state_d  = GRANT;
               owner_d  = pick_idx;
               wd_cnt_d = '0;
            end
         end
         GRANT: begin
            wd_cnt_d = wd_cnt_q + TW'(1);
            if (!req_active[owner_q]) begin
               state_d  = RELEASE;
               rr_ptr_d = owner_q;
            end else if (wd_cnt_q == TW'(TIMEOUT-1)) begin
               state_d       = RELEASE;
               rr_ptr_d      = owner_q;
               timeout_err_d = 1'b1;
            end
         end
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      grant       = (state_q == GRANT) ? (N'(1) << owner_q) : '0;
      busy        = (state_q == GRANT);
      timeout_err = timeout_err_q;
   end

   always_comb begin
      sel_x      = '0;
      sel_y      = '0;
      sel_colour = '0;
      for (int i = 0; i < N; i++) begin
         if (owner_q == PW'(i)) begin
            sel_x      = req_x[i*X_W +: X_W];
            sel_y      = req_y[i*Y_W +: Y_W];
            sel_colour = req_colour[i*C_W +: C_W];
         end
      end
   end

   // The owner's write is honoured on its last GRANT cycle even if active has dropped.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         vga_x_q      <= '0;
         vga_y_q      <= '0;
         vga_colour_q <= '0;
         vga_plot_q   <= 1'b0;
      end else begin
         vga_plot_q <= (state_q == GRANT) & req_write[owner_q];
         if (state_q == GRANT) begin
            vga_x_q      <= sel_x;
            vga_y_q      <= sel_y;
            vga_colour_q <= sel_colour;
         end
      end
   end

   assign vga_x      = vga_x_q;
   assign vga_y      = vga_y_q;
   assign vga_colour = vga_colour_q;
   assign vga_plot   = vga_plot_q;

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// tb/tb_pixel_write_arbiter.sv - vector table, directed corner sequences and random run against a reference model
module tb_pixel_write_arbiter;
   import draw_pkg::*;

   localparam int N       = 4;
   localparam int TIMEOUT = 8;
   localparam int TW      = 4;

   logic           clk = 1'b0;
   logic           resetn;
   logic [N-1:0]   req_active;
   logic [8*N-1:0] req_x;
   logic [7*N-1:0] req_y;
   logic [3*N-1:0] req_colour;
   logic [N-1:0]   req_write;
   logic [N-1:0]   grant;
   logic [7:0]     vga_x;
   logic [6:0]     vga_y;
   logic [2:0]     vga_colour;
   logic           vga_plot;
   logic           busy;
   logic           timeout_err;

   pixel_write_arbiter #(.N(N), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .req_active  (req_active),
      .req_x       (req_x),
      .req_y       (req_y),
      .req_colour  (req_colour),
      .req_write   (req_write),
      .grant       (grant),
      .vga_x       (vga_x),
      .vga_y       (vga_y),
      .vga_colour  (vga_colour),
      .vga_plot    (vga_plot),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_model = 1'b0;

   // Reference model: owner is -1 when nobody holds the port, dead counts grant-low cycles left.
   int          m_owner, m_last, m_dead, m_held;
   logic        m_plot, m_terr;
   logic [7:0]  m_x;
   logic [6:0]  m_y;
   logic [2:0]  m_c;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      if (!resetn) begin
         m_owner = -1; m_last = N-1; m_dead = 0; m_held = 0;
         m_plot = 0; m_terr = 0; m_x = 0; m_y = 0; m_c = 0;
         return;
      end
      m_plot = 0;
      m_terr = 0;
      if (m_owner >= 0) begin
         m_plot = req_write[m_owner];
         m_x = req_x[m_owner*8 +: 8];
         m_y = req_y[m_owner*7 +: 7];
         m_c = req_colour[m_owner*3 +: 3];
         m_held++;
         if (!req_active[m_owner]) begin
            m_last = m_owner; m_owner = -1; m_dead = 1;
         end else if (m_held == TIMEOUT) begin
            m_last = m_owner; m_owner = -1; m_dead = 1; m_terr = 1;
         end
      end else if (m_dead > 0) begin
         m_dead--;
      end else begin
         for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_last + k) % N;
            if (req_active[c]) begin
               m_owner = c;
               m_held = 0;
               break;
            end
         end
      end
   endtask

   task automatic tick();
      logic [N-1:0] eg;
      @(posedge clk);
      model_step();
      #1;
      if (chk_model) begin
         eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
         n_checks++;
         if (grant !== eg || busy !== (m_owner >= 0) || vga_plot !== m_plot ||
             timeout_err !== m_terr || vga_x !== m_x || vga_y !== m_y || vga_colour !== m_c) begin
            n_fail++;
            $display("FAIL model: got g=%b b=%b p=%b t=%b xyc=%0d,%0d,%0d expected g=%b b=%b p=%b t=%b xyc=%0d,%0d,%0d",
                     grant, busy, vga_plot, timeout_err, vga_x, vga_y, vga_colour,
                     eg, (m_owner >= 0), m_plot, m_terr, m_x, m_y, m_c);
         end
      end
   endtask

   task automatic set_client(input int i, input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
      req_x[i*8 +: 8] = x;
      req_y[i*7 +: 7] = y;
      req_colour[i*3 +: 3] = c;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
   endtask

   typedef struct {
      logic       rst_n;
      logic [3:0] act;
      logic [3:0] wr;
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
      logic [3:0] eg;
      logic       ep;
      logic [7:0] ex;
      logic [6:0] ey;
      logic [2:0] ec;
   } vec_t;

   vec_t vecs[12];

   initial begin
      int n;
      logic [3:0] exp_seq[5];
      logic [3:0] g;

      vecs[0]  = '{1'b0, 4'b0000, 4'b0000,   0,  0, 0, 4'b0000, 1'b0,   0,  0, 0};
      vecs[1]  = '{1'b0, 4'b0001, 4'b0001, 146, 87, 7, 4'b0000, 1'b0,   0,  0, 0};
      vecs[2]  = '{1'b1, 4'b0001, 4'b0001, 146, 87, 7, 4'b0001, 1'b0,   0,  0, 0};
      vecs[3]  = '{1'b1, 4'b0001, 4'b0001, 146, 87, 7, 4'b0001, 1'b1, 146, 87, 7};
      vecs[4]  = '{1'b1, 4'b0001, 4'b0000, 149, 98, 7, 4'b0001, 1'b0, 149, 98, 7};
      vecs[5]  = '{1'b1, 4'b0000, 4'b0001, 149, 98, 7, 4'b0000, 1'b1, 149, 98, 7};
      vecs[6]  = '{1'b1, 4'b0000, 4'b0000, 149, 98, 7, 4'b0000, 1'b0, 149, 98, 7};
      vecs[7]  = '{1'b1, 4'b0001, 4'b0000, 149, 98, 7, 4'b0001, 1'b0, 149, 98, 7};
      vecs[8]  = '{1'b1, 4'b0000, 4'b0000, 149, 98, 7, 4'b0000, 1'b0, 149, 98, 7};
      vecs[9]  = '{1'b1, 4'b0010, 4'b0000, 149, 98, 7, 4'b0000, 1'b0, 149, 98, 7};
      vecs[10] = '{1'b1, 4'b0010, 4'b0000, 149, 98, 7, 4'b0010, 1'b0, 149, 98, 7};
      vecs[11] = '{1'b1, 4'b0000, 4'b0000, 149, 98, 7, 4'b0000, 1'b0,   0,  0, 0};

      resetn = 1'b0; req_active = '0; req_write = '0;
      req_x = '0; req_y = '0; req_colour = '0;

      // Single client, release-cycle write, re-grant gap and hand-over to client 1
      for (int i = 0; i < 12; i++) begin
         resetn = vecs[i].rst_n;
         req_active = vecs[i].act;
         req_write = vecs[i].wr;
         req_x = '0; req_y = '0; req_colour = '0;
         set_client(0, vecs[i].x, vecs[i].y, vecs[i].c);
         tick();
         check($sformatf("vec%0d grant", i), grant, vecs[i].eg);
         check($sformatf("vec%0d busy", i), busy, (vecs[i].eg != 0));
         check($sformatf("vec%0d plot", i), vga_plot, vecs[i].ep);
         check($sformatf("vec%0d xyc", i), {vga_x, vga_y, vga_colour}, {vecs[i].ex, vecs[i].ey, vecs[i].ec});
         check($sformatf("vec%0d terr", i), timeout_err, 1'b0);
      end

      // Round-robin with every client requesting, each dropping after 4 granted cycles
      req_active = 4'b1111; req_write = '0;
      do_reset();
      exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
      exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
      for (int e = 0; e < 5; e++) begin
         n = 0;
         do begin tick(); n++; end while (grant == 0 && n < 10);
         check($sformatf("rr%0d grant", e), grant, exp_seq[e]);
         check($sformatf("rr%0d gap", e), n, (e == 0) ? 1 : 2);
         g = grant;
         for (int h = 0; h < 3; h++) begin
            tick();
            check($sformatf("rr%0d hold", e), grant, g);
         end
         req_active = 4'b1111 & ~g;
         tick();
         check($sformatf("rr%0d release", e), grant, 4'b0000);
         req_active = 4'b1111;
      end

      // Non-owner writes never reach the port
      req_active = 4'b0000; req_write = '0;
      do_reset();
      req_active = 4'b0010; req_write = 4'b0100;
      set_client(1, 8'd33, 7'd44, WHITE);
      set_client(2, 8'd10, 7'd10, 3'd5);
      for (int i = 0; i < 6; i++) begin
         tick();
         check("iso plot", vga_plot, 1'b0);
         check("iso x", (vga_x == 8'd10), 1'b0);
      end
      check("iso grant", grant, 4'b0010);

      // Watchdog on a client that never lets go
      req_active = 4'b0000; req_write = '0;
      do_reset();
      req_active = 4'b1000;
      tick();
      check("wd first grant", grant, 4'b1000);
      req_active = 4'b1001;
      n = 1;
      while (n < 20) begin
         tick();
         if (grant == 4'b1000) n++;
         else break;
      end
      check("wd grant cycles", n, TIMEOUT);
      check("wd terr pulse", timeout_err, 1'b1);
      check("wd grant low", grant, 4'b0000);
      tick();
      check("wd terr end", timeout_err, 1'b0);
      check("wd gap", grant, 4'b0000);
      tick();
      check("wd next client", grant, 4'b0001);

      // Reset while client 2 is plotting
      req_active = 4'b0000; req_write = '0;
      do_reset();
      req_active = 4'b0100; req_write = 4'b0100;
      set_client(2, 8'd50, 7'd20, 3'd3);
      tick();
      check("mid grant", grant, 4'b0100);
      tick();
      check("mid plot", vga_plot, 1'b1);
      resetn = 1'b0;
      tick();
      check("mid rst grant", grant, 4'b0000);
      check("mid rst plot", vga_plot, 1'b0);
      check("mid rst busy", busy, 1'b0);
      resetn = 1'b1; req_active = 4'b0101;
      tick();
      check("mid restart", grant, 4'b0001);

      // Random traffic against the model
      req_active = '0; req_write = '0;
      do_reset();
      chk_model = 1'b1;
      for (int i = 0; i < 600; i++) begin
         for (int b = 0; b < N; b++) begin
            if ($urandom_range(7) == 0) req_active[b] = ~req_active[b];
         end
         req_write = N'($urandom);
         req_x = (8*N)'({$urandom, $urandom});
         req_y = (7*N)'($urandom);
         req_colour = (3*N)'($urandom);
         resetn = ($urandom_range(79) != 0);
         tick();
      end
      chk_model = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
